// File: rtl/seq_detect_pkg.sv
// Shared types for the programmable sequence detector.
// Holds the FSM state encoding and the index-width helper.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index width for a DEPTH-entry table, never narrower than one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/seq_detect_fsm_regs.sv
// Pattern register file: DEPTH entries of (value, mask).
// Two compare ports: the current step and step zero.
module seq_pattern_regs
    import seq_detect_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [idx_w(DEPTH)-1:0]   idx,
    input  logic [W-1:0]              val,
    input  logic [W-1:0]              mask,
    input  logic [idx_w(DEPTH)-1:0]   step,
    input  logic                      sym_valid,
    input  logic [W-1:0]              sym,
    output logic                      match_step,
    output logic                      match_first
);

    logic [W-1:0] val_q  [DEPTH];
    logic [W-1:0] mask_q [DEPTH];

    // Table write; cleared masks make every valid symbol match after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else if (we) begin
            val_q[idx]  <= val;
            mask_q[idx] <= mask;
        end
    end

    // Masked compare of the observed symbol against both read ports.
    always_comb begin
        match_step  = sym_valid && (((sym ^ val_q[step]) & mask_q[step]) == '0);
        match_first = sym_valid && (((sym ^ val_q[0]) & mask_q[0]) == '0);
    end

endmodule

// File: rtl/seq_detect_fsm.sv
// Programmable masked sequence detector with gap timeout,
// optional back-to-back matching and a saturating hit counter.
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int W       = 2,
    parameter int DEPTH   = 3,
    parameter int MAX_GAP = 4,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [idx_w(DEPTH)-1:0] cfg_idx,
    input  logic [W-1:0]            cfg_val,
    input  logic [W-1:0]            cfg_mask,
    input  logic                    mode_overlap,
    input  logic                    sym_valid,
    input  logic [W-1:0]            sym,
    output logic                    busy,
    output logic [idx_w(DEPTH)-1:0] step,
    output logic                    hit,
    output logic                    active,
    output logic                    timeout,
    output logic                    cfg_err,
    output logic [CNT_W-1:0]        hit_count
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam int GAP_W = $clog2(MAX_GAP + 1);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(MAX_GAP - 1);
    localparam logic [IDX_W-1:0] FIRST_STEP = (DEPTH == 1) ? '0 : IDX_W'(1);

    state_t           state, state_n;
    logic [IDX_W-1:0] step_n;
    logic [GAP_W-1:0] gap, gap_n;
    logic             timeout_n;
    logic             match_step, match_first;
    logic             cfg_ok, cfg_acc;
    state_t           first_state;

    assign first_state = (DEPTH == 1) ? DONE : TRACK;

    seq_pattern_regs #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .we          (cfg_acc),
        .idx         (cfg_idx),
        .val         (cfg_val),
        .mask        (cfg_mask),
        .step        (step),
        .sym_valid   (sym_valid),
        .sym         (sym),
        .match_step  (match_step),
        .match_first (match_first)
    );

    // Next-state logic: step tracking, restart, gap expiry.
    always_comb begin
        state_n   = state;
        step_n    = step;
        gap_n     = gap;
        timeout_n = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                gap_n = '0;
                if (match_first && (state == IDLE || mode_overlap)) begin
                    state_n = first_state;
                    step_n  = FIRST_STEP;
                end else begin
                    state_n = IDLE;
                    step_n  = '0;
                end
            end
            TRACK: begin
                if (sym_valid) begin
                    gap_n = '0;
                    if (match_step && step == LAST) begin
                        state_n = DONE;
                        step_n  = '0;
                    end else if (match_step) begin
                        step_n = step + 1'b1;
                    end else if (match_first) begin
                        step_n = FIRST_STEP;
                    end else begin
                        state_n = IDLE;
                        step_n  = '0;
                    end
                end else if (gap == GAP_END) begin
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                    step_n    = '0;
                    gap_n     = '0;
                end else begin
                    gap_n = gap + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                step_n  = '0;
                gap_n   = '0;
            end
        endcase
    end

    // Writes only land while the FSM stays parked in IDLE.
    always_comb begin
        cfg_ok  = (state == IDLE) && (state_n == IDLE)
                  && (int'(cfg_idx) < DEPTH);
        cfg_acc = cfg_we && cfg_ok;
    end

    // State, counters and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            gap       <= '0;
            hit       <= 1'b0;
            timeout   <= 1'b0;
            cfg_err   <= 1'b0;
            hit_count <= '0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            gap     <= gap_n;
            hit     <= (state_n == DONE);
            timeout <= timeout_n;
            cfg_err <= cfg_we && !cfg_ok;
            if (state_n == DONE && hit_count != '1)
                hit_count <= hit_count + 1'b1;
        end
    end

    // Status decodes.
    always_comb begin
        busy   = (state != IDLE);
        active = (state == IDLE) && sym_valid && (|sym);
    end

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Self-checking bench for seq_detect_fsm (W=2, DEPTH=3, MAX_GAP=2, CNT_W=2).
// Reference model pushes expected outputs; samples after each edge pop them.
module tb_seq_detect_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [1:0] cfg_val = '0;
    logic [1:0] cfg_mask = '0;
    logic       mode_overlap = 1'b0;
    logic       sym_valid = 1'b0;
    logic [1:0] sym = '0;
    logic       busy, hit, active, timeout, cfg_err;
    logic [1:0] step;
    logic [1:0] hit_count;

    seq_detect_fsm #(
        .W       (2),
        .DEPTH   (3),
        .MAX_GAP (2),
        .CNT_W   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_val      (cfg_val),
        .cfg_mask     (cfg_mask),
        .mode_overlap (mode_overlap),
        .sym_valid    (sym_valid),
        .sym          (sym),
        .busy         (busy),
        .step         (step),
        .hit          (hit),
        .active       (active),
        .timeout      (timeout),
        .cfg_err      (cfg_err),
        .hit_count    (hit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic       timeout;
        logic       cfg_err;
        logic       busy;
        logic [1:0] step;
        logic [1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hits    = 0;
    int   touts   = 0;

    // model state: 0 idle, 1 track, 2 done
    int         m_state = 0;
    int         m_step  = 0;
    int         m_gap   = 0;
    int         m_cnt   = 0;
    logic [1:0] m_val  [3] = '{default: 2'b00};
    logic [1:0] m_mask [3] = '{default: 2'b00};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit mt(input int i, input logic v, input logic [1:0] s);
        return v && (((s ^ m_val[i]) & m_mask[i]) == 2'b00);
    endfunction

    // One clock of stimulus; model predicts, then outputs are compared.
    task automatic cyc(input logic v, input logic [1:0] s,
                       input logic r = 1'b0, input logic we = 1'b0,
                       input logic [1:0] idx = 2'd0,
                       input logic [1:0] cv = 2'd0,
                       input logic [1:0] cm = 2'd0);
        int   ns, nst, ng;
        bit   to, err;
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst = r; sym_valid = v; sym = s;
        cfg_we = we; cfg_idx = idx; cfg_val = cv; cfg_mask = cm;
        #1;
        chk("active", 32'(active), 32'(m_state == 0 && v && s != 2'b00));
        ns = m_state; nst = m_step; ng = m_gap; to = 0; err = 0;
        if (r) begin
            ns = 0; nst = 0; ng = 0; m_cnt = 0;
            m_val  = '{default: 2'b00};
            m_mask = '{default: 2'b00};
        end else begin
            if (m_state == 0 || (m_state == 2 && mode_overlap)) begin
                ng = 0;
                if (mt(0, v, s)) begin ns = 1; nst = 1; end
                else begin ns = 0; nst = 0; end
            end else if (m_state == 2) begin
                ns = 0; nst = 0; ng = 0;
            end else if (v) begin
                ng = 0;
                if (mt(m_step, v, s)) begin
                    if (m_step == 2) begin ns = 2; nst = 0; end
                    else nst = m_step + 1;
                end else if (mt(0, v, s)) nst = 1;
                else begin ns = 0; nst = 0; end
            end else begin
                ng = m_gap + 1;
                if (ng == 2) begin to = 1; ns = 0; nst = 0; ng = 0; end
            end
            if (we) begin
                if (m_state == 0 && ns == 0 && idx < 3) begin
                    m_val[idx]  = cv;
                    m_mask[idx] = cm;
                end else err = 1;
            end
            if (ns == 2 && m_cnt < 3) m_cnt++;
        end
        m_state = ns; m_step = nst; m_gap = ng;
        e.hit = (ns == 2); e.timeout = to; e.cfg_err = err;
        e.busy = (ns != 0); e.step = 2'(nst); e.cnt = 2'(m_cnt);
        q.push_back(e);
        @(posedge clk);
        #1;
        g = '{hit, timeout, cfg_err, busy, step, hit_count};
        if (q.size() == 0) begin
            chk("queue_empty", 32'(1), 32'(0));
        end else begin
            e = q.pop_front();
            chk("hit", 32'(g.hit), 32'(e.hit));
            chk("timeout", 32'(g.timeout), 32'(e.timeout));
            chk("cfg_err", 32'(g.cfg_err), 32'(e.cfg_err));
            chk("busy", 32'(g.busy), 32'(e.busy));
            chk("step", 32'(g.step), 32'(e.step));
            chk("hit_count", 32'(g.cnt), 32'(e.cnt));
        end
        hits  += int'(hit);
        touts += int'(timeout);
        rst = 1'b0; cfg_we = 1'b0; sym_valid = 1'b0;
    endtask

    task automatic reset_prog();
        cyc(0, 2'b00, 1'b1);
        cyc(0, 2'b00, 1'b1);
        cyc(0, 2'b00, 0, 1, 2'd0, 2'b01, 2'b11);
        cyc(0, 2'b00, 0, 1, 2'd1, 2'b10, 2'b11);
        cyc(0, 2'b00, 0, 1, 2'd2, 2'b11, 2'b11);
    endtask

    task automatic seq3();
        cyc(1, 2'b01); cyc(1, 2'b10); cyc(1, 2'b11);
    endtask

    initial begin
        // reset state
        cyc(0, 2'b00, 1'b1);
        chk("rst_cnt", 32'(hit_count), 32'(0));
        chk("rst_hit", 32'(hit), 32'(0));

        // basic detection, step 1,2,0
        reset_prog();
        hits = 0;
        seq3();
        cyc(0, 2'b00);
        chk("basic_hits", 32'(hits), 32'(1));
        chk("basic_cnt", 32'(hit_count), 32'(1));

        // restart on repeated first symbol
        reset_prog();
        hits = 0;
        cyc(1, 2'b01); seq3(); cyc(0, 2'b00);
        chk("restart_hits", 32'(hits), 32'(1));
        cyc(1, 2'b01); cyc(1, 2'b00);
        chk("abort_idle", 32'(busy), 32'(0));
        chk("abort_cnt", 32'(hit_count), 32'(1));

        // gap timeout and tolerated gap
        touts = 0;
        cyc(1, 2'b01); cyc(0, 2'b00); cyc(0, 2'b00);
        chk("timeouts", 32'(touts), 32'(1));
        chk("tout_idle", 32'(busy), 32'(0));
        hits = 0;
        cyc(1, 2'b01); cyc(0, 2'b00); cyc(1, 2'b10); cyc(1, 2'b11);
        cyc(0, 2'b00);
        chk("gap_hits", 32'(hits), 32'(1));

        // back-to-back with and without overlap
        mode_overlap = 1'b1;
        hits = 0;
        seq3(); seq3(); cyc(0, 2'b00);
        chk("ovl1_hits", 32'(hits), 32'(2));
        mode_overlap = 1'b0;
        hits = 0;
        seq3(); seq3(); cyc(0, 2'b00);
        chk("ovl0_hits", 32'(hits), 32'(1));

        // counter saturation
        reset_prog();
        for (int i = 0; i < 5; i++) begin
            seq3();
            cyc(0, 2'b00);
        end
        chk("sat_cnt", 32'(hit_count), 32'(3));

        // rejected writes: mid-TRACK, leaving IDLE, index out of range
        reset_prog();
        hits = 0;
        cyc(1, 2'b01, 0, 1, 2'd0, 2'b00, 2'b11);
        cyc(1, 2'b10, 0, 1, 2'd0, 2'b00, 2'b11);
        chk("trk_err", 32'(cfg_err), 32'(1));
        cyc(1, 2'b11);
        cyc(0, 2'b00, 0, 1, 2'd3, 2'b00, 2'b00);
        chk("idx_err", 32'(cfg_err), 32'(1));
        chk("wr_hits", 32'(hits), 32'(1));

        // reset mid-TRACK clears count and pattern
        cyc(1, 2'b01);
        cyc(1, 2'b10, 1'b1);
        chk("rst_trk_busy", 32'(busy), 32'(0));
        chk("rst_trk_cnt", 32'(hit_count), 32'(0));
        cyc(1, 2'b10);
        chk("cfg_cleared", 32'(busy), 32'(1));

        // random traffic against the model
        reset_prog();
        for (int i = 0; i < 200; i++) begin
            mode_overlap = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 60) == 0),
                1'($urandom_range(0, 12) == 0),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_fsm.md
# seq_detect_fsm

Parametrised, programmable sequence-detector FSM for control-path monitoring. It replaces fixed two-input, three-state detectors with one block that matches a run-time configurable sequence of `DEPTH` masked `W`-bit symbols. The block supports an inter-symbol gap timeout, an optional back-to-back (overlap) mode and a saturating hit counter. It sits beside the datapath it observes and drives status and interrupt-style pulses.

## Interface
- `W`, 2: symbol width.
- `DEPTH`, 3: number of sequence steps, ≥1.
- `MAX_GAP`, 4: consecutive idle cycles (`sym_valid`=0) tolerated mid-sequence, ≥1.
- `CNT_W`, 8: hit counter width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_we` in 1: pattern write strobe.
- `cfg_idx` in `$clog2(DEPTH)` (min 1): step being written.
- `cfg_val` in `W`: expected symbol for the step.
- `cfg_mask` in `W`: 1 = compare bit, 0 = don't care.
- `mode_overlap` in 1: 1 = DONE cycle also evaluates its symbol.
- `sym_valid` in 1: symbol qualifier.
- `sym` in `W`: observed symbol.
- `busy` out 1: state ≠ IDLE.
- `step` out `$clog2(DEPTH)`: index of next step to match.
- `hit` out 1: registered, high in DONE.
- `active` out 1: combinational; IDLE && `sym_valid` && `|sym`.
- `timeout` out 1: one-cycle registered pulse.
- `cfg_err` out 1: one-cycle registered pulse on a rejected write.
- `hit_count` out `CNT_W`: saturating count of DONE entries.

## Operation
- `match(i)` = `((sym ^ val[i]) & mask[i]) == 0` && `sym_valid`.
- States: IDLE, TRACK, DONE.
- IDLE:
  - `match(0)` → DONE if `DEPTH`==1, else TRACK with `step`=1.
  - Otherwise stay in IDLE.
- TRACK, `sym_valid`=1:
  - `match(step)` with `step`==`DEPTH`-1 → DONE.
  - `match(step)` otherwise → `step`+1.
  - Mismatch: if `match(0)`, restart with `step`=1; else go to IDLE with `step`=0.
  - Every valid symbol clears the gap counter.
- TRACK, `sym_valid`=0:
  - Gap counter increments.
  - When it reaches `MAX_GAP`: `timeout` pulse, go to IDLE, `step`=0.
- DONE lasts exactly one cycle; `hit`=1.
  - `mode_overlap`=1: the symbol is evaluated as in IDLE.
  - `mode_overlap`=0: the symbol is ignored and the next state is IDLE.
- `hit_count` increments on every IDLE/TRACK/DONE→DONE transition and saturates at all-ones.
- Config writes:
  - Accepted only when state is IDLE and the transition out of IDLE is not occurring in that cycle.
  - A write takes effect on the following cycle.
  - Any other write is dropped and `cfg_err` pulses.
  - A write with `cfg_idx` ≥ `DEPTH` is also dropped with `cfg_err`.
- Unreachable state encodings → IDLE.

## Timing
- Reset values:
  - state IDLE, `step` 0, gap counter 0.
  - `hit`, `timeout`, `cfg_err`, `busy` all 0; `hit_count` 0.
  - All `val`/`mask` 0, so any valid symbol matches.
- Reset has priority over every input. Reset mid-TRACK or mid-DONE gives IDLE on the next edge, with no `hit` and no `timeout`.
- Latency: final matching symbol sampled at edge N → `hit` high during cycle N..N+1 (one clock).
- `timeout` is asserted in the cycle following the `MAX_GAP`-th idle edge.
- `active` has zero latency. It is the only combinational output.
- Simultaneous mismatch and gap expiry cannot occur: a valid symbol clears the gap counter.

## Structure
- Package `seq_detect_pkg`: `state_t` enum (IDLE=2'd0, TRACK=2'd1, DONE=2'd2) and the `IDX_W` computation function.
- Sub-module `seq_pattern_regs` holds the `DEPTH`×(`val`,`mask`) register file:
  - write port: `cfg_we` gated by the accept condition;
  - read port: indexed by `step` and by index 0;
  - outputs: `match_step` and `match_first`.
- The top level holds the FSM, gap counter, hit counter and pulse registers.

## Test plan
Default configuration: `W`=2, `DEPTH`=3, pattern 01,10,11, masks 11.
- Reset, then valid 01,10,11 on consecutive cycles → `hit` for 1 cycle after 11, `hit_count`=1, `step` sequence 1,2,0.
- 01,01,10,11 → `hit` once, because the second 01 restarts. Separately, 01,00 → IDLE with `hit_count` unchanged.
- `MAX_GAP`=2:
  - 01, then 2 invalid cycles → `timeout` pulse, IDLE.
  - 01, 1 invalid cycle, 10, 11 → `hit`.
- 01,10,11,01,10,11 back-to-back:
  - `mode_overlap`=1 → 2 hits;
  - `mode_overlap`=0 → 1 hit.
- `CNT_W`=2, 5 complete sequences → `hit_count`=3.
- Write while TRACK → `cfg_err`, pattern unchanged. Assert `rst` mid-TRACK → IDLE, `hit_count`=0, `cfg` cleared.
